// File: rtl/debug_trace_buffer_if.sv
// debug_trace_buffer_if: probe capture, control and display read signals of the trace buffer.
// master drives probes/control/read selects; slave is the buffer.
interface debug_trace_buffer_if #(
    parameter int NCH = 8,
    parameter int W = 32,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(NCH + 1);
    logic             cap_en;
    logic [NCH*W-1:0] probe;
    logic [1:0]       mode;
    logic             arm;
    logic [W-1:0]     trig_val;
    logic [AW-1:0]    post_cnt;
    logic [AW-1:0]    rd_age;
    logic [CW-1:0]    rd_ch;
    logic [W-1:0]     rd_data;
    logic [1:0]       state;
    logic [AW:0]      fill;
    logic             triggered;
    modport master (
        output cap_en, probe, mode, arm, trig_val, post_cnt, rd_age, rd_ch,
        input  rd_data, state, fill, triggered
    );
    modport slave (
        input  cap_en, probe, mode, arm, trig_val, post_cnt, rd_age, rd_ch,
        output rd_data, state, fill, triggered
    );
endinterface

// File: rtl/debug_trace_buffer.sv
// debug_trace_buffer: circular DEPTH-deep history of NCH probe channels with continuous,
// triggered and single-shot capture; TRACE_TIMESTAMP_EN stores a cycle stamp readable at rd_ch=NCH.
module debug_trace_buffer #(
    parameter int NCH = 8,
    parameter int W = 32,
    parameter int DEPTH = 16
) (
    input logic clk,
    input logic reset,
    debug_trace_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(NCH + 1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_POST = 2'd2, S_DONE = 2'd3;
    localparam logic [1:0] M_TRIG = 2'b01, M_SINGLE = 2'b10, M_PAUSE = 2'b11;

    logic [NCH*W-1:0] mem_q [DEPTH];
    logic [NCH*W-1:0] row;
    logic [1:0]       state_q, state_d;
    logic [AW-1:0]    wptr_q, wptr_d, cnt_q, cnt_d, rd_idx;
    logic [AW:0]      fill_q, fill_d;
    logic             trig_q, trig_d, wr, hit, rd_valid;
    logic [W-1:0]     rd_q, rd_d, ts_rd;

    assign wr  = bus.cap_en && !bus.arm && bus.mode != M_PAUSE && (state_q == S_RUN || state_q == S_POST);
    assign hit = state_q == S_RUN && bus.mode == M_TRIG && bus.probe[W-1:0] == bus.trig_val;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        trig_d  = trig_q;
        if (bus.arm) begin
            state_d = S_RUN;
            wptr_d  = '0;
            fill_d  = '0;
            cnt_d   = '0;
            trig_d  = 1'b0;
        end else if (wr) begin
            wptr_d = wptr_q + 1'b1;
            fill_d = fill_q == FULL ? fill_q : fill_q + 1'b1;
            // POST keeps counting down whatever mode is selected now
            if (state_q == S_POST) begin
                cnt_d   = cnt_q - 1'b1;
                state_d = cnt_q == AW'(1) ? S_DONE : S_POST;
            end else if (hit) begin
                trig_d  = 1'b1;
                cnt_d   = bus.post_cnt;
                state_d = bus.post_cnt == '0 ? S_DONE : S_POST;
            end else if (bus.mode == M_SINGLE && fill_d == FULL) begin
                state_d = S_DONE;
            end
        end
    end

    assign rd_idx   = wptr_q - AW'(1) - bus.rd_age;
    assign row      = mem_q[rd_idx];
    assign rd_valid = {1'b0, bus.rd_age} < fill_q;

    always_comb begin
        rd_d = '0;
        if (rd_valid && bus.rd_ch < CW'(NCH)) rd_d = row[int'(bus.rd_ch)*W +: W];
        else if (rd_valid && bus.rd_ch == CW'(NCH)) rd_d = ts_rd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
            rd_q    <= rd_d;
        end
    end

    // Storage is not reset; the read path sees the pre-write contents of mem_q[wptr_q]
    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q] <= bus.probe;
    end

`ifdef TRACE_TIMESTAMP_EN
    logic [W-1:0] ts_q;
    logic [W-1:0] ts_mem_q [DEPTH];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ts_q <= '0;
        else ts_q <= ts_q + 1'b1;
    end
    always_ff @(posedge clk) begin
        if (wr) ts_mem_q[wptr_q] <= ts_q;
    end
    assign ts_rd = ts_mem_q[rd_idx];
`else
    assign ts_rd = '0;
`endif

    assign bus.rd_data   = rd_q;
    assign bus.state     = state_q;
    assign bus.fill      = fill_q;
    assign bus.triggered = trig_q;
endmodule

// File: tb/tb_debug_trace_buffer.sv
// tb_debug_trace_buffer: directed checks of reset, continuous, triggered, single-shot,
// arm priority, pause and timestamp reads of debug_trace_buffer.
module tb_debug_trace_buffer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] ts0, ts1;

    debug_trace_buffer_if #(.NCH(8), .W(32), .DEPTH(16)) bus ();
    debug_trace_buffer #(.NCH(8), .W(32), .DEPTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] v);
        for (int k = 0; k < 8; k++) bus.probe[k*32 +: 32] = v + 32'(k * 256);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic capture(input logic [31:0] v);
        bus.cap_en = 1'b1;
        put(v);
        tick();
        bus.cap_en = 1'b0;
    endtask

    task automatic do_arm();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
    endtask

    task automatic rd(input int age, input int ch);
        bus.rd_age = 4'(age);
        bus.rd_ch  = 4'(ch);
        tick();
    endtask

    initial begin
        bus.cap_en = 0; bus.probe = '0; bus.mode = 2'b00; bus.arm = 0;
        bus.trig_val = '0; bus.post_cnt = '0; bus.rd_age = '0; bus.rd_ch = '0;
        tick(); tick();
        chk("rst_state", bus.state, 0);
        chk("rst_fill", bus.fill, 0);
        chk("rst_trig", bus.triggered, 0);
        chk("rst_rd", bus.rd_data, 0);
        reset = 1'b1;
        tick();
        chk("idle_state", bus.state, 0);
        capture(32'h5);
        chk("idle_nowrite", bus.fill, 0);

        // reset mid-RUN
        do_arm();
        chk("arm_state", bus.state, 1);
        for (int i = 0; i < 5; i++) capture(32'(i));
        chk("t1_fill", bus.fill, 5);
        rd(0, 0);
        chk("t1_rd", bus.rd_data, 4);
        reset = 1'b0;
        #1;
        chk("t1_async_state", bus.state, 0);
        chk("t1_async_rd", bus.rd_data, 0);
        tick();
        chk("t1_state", bus.state, 0);
        chk("t1_fill0", bus.fill, 0);
        chk("t1_trig", bus.triggered, 0);
        chk("t1_rd0", bus.rd_data, 0);
        reset = 1'b1;
        tick();

        // continuous
        bus.mode = 2'b00;
        do_arm();
        for (int i = 0; i < 20; i++) capture(32'(i));
        chk("t2_fill", bus.fill, 16);
        chk("t2_state", bus.state, 1);
        rd(0, 0);  chk("t2_age0", bus.rd_data, 19);
        rd(15, 0); chk("t2_age15", bus.rd_data, 4);
        rd(0, 3);  chk("t2_ch3", bus.rd_data, 32'h313);
        rd(2, 7);  chk("t2_ch7", bus.rd_data, 32'h711);
        rd(0, 9);  chk("t2_ch9", bus.rd_data, 0);
        rd(0, 15); chk("t2_ch15", bus.rd_data, 0);
        bus.rd_age = 4'd15; bus.rd_ch = 4'd0;
        capture(32'd20);
        chk("t2_rbw", bus.rd_data, 4);
        rd(0, 0);  chk("t2_new", bus.rd_data, 20);
        rd(15, 0); chk("t2_oldest", bus.rd_data, 5);

        // triggered
        bus.mode = 2'b01; bus.trig_val = 32'h40; bus.post_cnt = 4'd3;
        do_arm();
        chk("t3_fill0", bus.fill, 0);
        for (int i = 0; i < 4; i++) capture(32'h30 + 32'(4 * i));
        chk("t3_pre_trig", bus.triggered, 0);
        chk("t3_pre_state", bus.state, 1);
        capture(32'h40);
        chk("t3_trig", bus.triggered, 1);
        chk("t3_post", bus.state, 2);
        capture(32'h44);
        capture(32'h40);
        chk("t3_post2", bus.state, 2);
        capture(32'h4C);
        chk("t3_done", bus.state, 3);
        chk("t3_fill", bus.fill, 8);
        rd(3, 0); chk("t3_age3", bus.rd_data, 32'h40);
        rd(0, 0); chk("t3_age0", bus.rd_data, 32'h4C);
        capture(32'h50);
        rd(0, 0); chk("t3_frozen", bus.rd_data, 32'h4C);
        chk("t3_frozen_fill", bus.fill, 8);
        rd(8, 0); chk("t3_beyond", bus.rd_data, 0);
        bus.post_cnt = 4'd0;
        do_arm();
        chk("t3_arm_clr", bus.triggered, 0);
        capture(32'h3F);
        capture(32'h40);
        chk("t3_p0_done", bus.state, 3);
        chk("t3_p0_trig", bus.triggered, 1);

        // single-shot
        bus.mode = 2'b10;
        do_arm();
        for (int i = 0; i < 15; i++) capture(32'd100 + 32'(i));
        chk("t4_pre_state", bus.state, 1);
        chk("t4_pre_fill", bus.fill, 15);
        capture(32'd115);
        chk("t4_done", bus.state, 3);
        chk("t4_fill", bus.fill, 16);
        capture(32'd999);
        rd(0, 0); chk("t4_age0", bus.rd_data, 115);

        // arm priority and pause
        bus.mode = 2'b00;
        do_arm();
        for (int i = 0; i < 3; i++) capture(32'(i));
        chk("t5_fill3", bus.fill, 3);
        bus.arm = 1'b1;
        capture(32'h77);
        bus.arm = 1'b0;
        chk("t5_fill0", bus.fill, 0);
        chk("t5_state", bus.state, 1);
        capture(32'h88);
        chk("t5_fill1", bus.fill, 1);
        rd(0, 0); chk("t5_age0", bus.rd_data, 32'h88);
        rd(1, 0); chk("t5_age1", bus.rd_data, 0);
        bus.mode = 2'b11;
        for (int i = 0; i < 4; i++) capture(32'h99);
        chk("t5_pause_fill", bus.fill, 1);
        chk("t5_pause_state", bus.state, 1);
        bus.mode = 2'b00;
        capture(32'hAA);
        chk("t5_resume", bus.fill, 2);

        // timestamp channel
        do_arm();
        capture(32'h1);
        tick(); tick();
        capture(32'h2);
        rd(0, 8); ts0 = bus.rd_data;
        rd(1, 8); ts1 = bus.rd_data;
`ifdef TRACE_TIMESTAMP_EN
        chk("t6_ts_delta", 64'(ts0 - ts1), 3);
`else
        chk("t6_ts0", ts0, 0);
        chk("t6_ts1", ts1, 0);
`endif
        rd(2, 8); chk("t6_ts_invalid", bus.rd_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/debug_trace_buffer.md
Name: debug_trace_buffer

Overview:
- Parametrised capture buffer between the pipelined CPU's debug probe outputs and the VGA debug display.
- Records NCH probe channels of W bits into a circular history of DEPTH samples, one sample per committed CPU clock.
- Supports continuous, PC-triggered and single-shot capture, so the display can show the last DEPTH pipeline snapshots instead of only the live values.
- The display reads any stored sample and channel through a registered read port.

Parameters:
- NCH, 8, number of probe channels; channel 0 is the trigger-compare channel (PC_fe).
- W, 32, width of each channel in bits.
- DEPTH, 16, history entries; power of 2, at least 2.
- AW, $clog2(DEPTH), derived pointer width; not overridden.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cap_en  in  1  sample strobe; high on cycles where the CPU pipeline advanced.
- probe  in  NCH*W  packed probe channels; channel k is probe[k*W +: W].
- mode  in  2  00 continuous, 01 triggered, 10 single-shot, 11 pause.
- arm  in  1  single-cycle pulse that starts or restarts capture.
- trig_val  in  W  value compared with channel 0 in triggered mode.
- post_cnt  in  AW  number of samples to record after the trigger sample.
- rd_age  in  AW  read select; 0 is the newest sample.
- rd_ch  in  $clog2(NCH+1)  read channel select.
- rd_data  out  W  registered read data.
- state  out  2  FSM state: 0 IDLE, 1 RUN, 2 POST, 3 DONE.
- fill  out  AW+1  number of valid entries, saturating at DEPTH.
- triggered  out  1  set when the trigger fires; cleared by arm.

Behaviour:
- Reset (asynchronous, reset low):
  - state=IDLE, wptr=0, fill=0, post counter=0.
  - triggered=0, rd_data=0.
  - Storage array is not reset.
  - Reset asserted mid-capture aborts capture immediately.
- IDLE: no writes. arm causes a transition to RUN, with wptr=0, fill=0, triggered=0.
- arm in any state restarts exactly as from IDLE. A cap_en in the same cycle as arm is dropped; arm has priority.
- Write: when a sample is written, probe goes to mem[wptr], wptr advances by 1 modulo DEPTH, and fill advances by 1, saturating at DEPTH.
- RUN, mode 00: write on every cap_en. Never leaves RUN.
- RUN, mode 01: write on every cap_en. If cap_en is high and channel 0 equals trig_val, that sample is written and triggered is set. Then:
  - post_cnt=0: go to DONE.
  - Otherwise: go to POST and load the counter with post_cnt.
- POST: write on every cap_en and decrement the counter. When a write happens with counter=1, go to DONE. A trigger match in POST is ignored.
- RUN, mode 10: write on every cap_en. The write that brings fill to DEPTH also moves to DONE.
- Mode 11: no writes in RUN or POST; state and counter hold. Capture resumes when mode changes.
- mode is sampled every cycle. A change from 01 to another mode while in POST completes POST unchanged.
- DONE: no writes. Contents are frozen until the next arm.
- Read:
  - rd_data is registered with 1-cycle latency.
  - It returns mem[(wptr-1-rd_age) mod DEPTH] channel rd_ch.
  - It returns 0 when rd_age >= fill or rd_ch >= NCH (excluding the timestamp channel).
  - Reads are allowed in all states.
- A write and a read of the same entry in the same cycle returns the old contents: read-before-write, consistent with the pointer update.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - A W-bit free-running cycle counter, cleared by reset and wrapping modulo 2^W, is stored alongside every written sample.
  - It is readable at rd_ch=NCH.
- Undefined:
  - No counter and no extra storage.
  - rd_ch=NCH returns 0.

Test Plan:
1. Reset low mid-RUN with fill=5 -> next cycle: state=0, fill=0, triggered=0, rd_data=0.
2. Mode 00, arm, 20 cap_en pulses with channel 0 = 0..19 -> fill=16, state=1; rd_age=0/ch0 gives 19 and rd_age=15 gives 4, each one cycle after the select.
3. Mode 01, trig_val=0x40, post_cnt=3, channel 0 sequence 0x30,0x34,...; 0x40 is hit -> triggered=1, state=2. After 3 more cap_en, state=3. rd_age=3 gives 0x40 and rd_age=0 gives 0x4C; further cap_en leave contents unchanged.
4. Mode 10, arm, 16 cap_en -> state=3 on the 16th write with fill=16. A 17th cap_en does not change rd_age=0 data.
5. arm and cap_en in the same cycle during RUN -> fill=0 the next cycle and the sample is not stored. Mode 11 with 4 cap_en -> fill unchanged.
6. With TRACE_TIMESTAMP_EN, cap_en at cycles 10 and 13 after reset -> rd_ch=NCH reads 13 at rd_age=0 and 10 at rd_age=1. Without the macro the same reads return 0.
